tlb_ctrl: RTL and testbench
===========================

# tlb_ctrl

Sequencer and arbiter in front of the set-associative TLB array. It accepts translation requests from the instruction-fetch and data ports, arbitrates round-robin, and drives one lookup at a time into the TLB. On a miss it runs a page-walk handshake, refills the TLB, and returns the physical address or a fault. It also serializes full-TLB invalidations and keeps saturating hit and miss counters.

## Interface
- ADDR, 64, virtual/physical address width in bits
- PAGE, 12, page-offset width in bits; VPN/PPN width is ADDR-PAGE
- PCID, 12, process-context ID width
- CNT, 16, width of the statistics counters

Ports (clock and reset first):
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- i_valid / i_ready  in / out  1 / 1  fetch request handshake
- i_vaddr / i_pcid  in  ADDR / PCID  fetch request payload
- d_valid / d_ready  in / out  1 / 1  data request handshake
- d_vaddr / d_pcid  in  ADDR / PCID  data request payload
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_id  out  1  0 = fetch, 1 = data
- rsp_paddr  out  ADDR  {ppn, latched offset}; 0 when rsp_fault
- rsp_fault  out  1  walk reported a fault
- lk_valid  out  1  lookup request to the TLB, held until lk_done
- lk_vpn / lk_pcid  out  ADDR-PAGE / PCID  lookup key
- lk_done / lk_hit / lk_ppn  in  1 / 1 / ADDR-PAGE  lookup result, valid when lk_done
- walk_valid  out  1  page-walk request, held until walk_done
- walk_vpn / walk_pcid  out  ADDR-PAGE / PCID  walk key
- walk_done / walk_fault / walk_ppn  in  1 / 1 / ADDR-PAGE  walk result
- fill_en  out  1  one-cycle TLB refill strobe
- fill_vpn / fill_pcid / fill_ppn  out  ADDR-PAGE / PCID / ADDR-PAGE  refill entry
- flush_req  in  1  level request to invalidate the whole TLB
- tlb_inv  out  1  one-cycle invalidate strobe to the TLB
- flush_ack  out  1  one-cycle pulse, same cycle as tlb_inv
- hit_cnt / miss_cnt  out  CNT / CNT  saturating lookup statistics

## Operation
- States: IDLE, LOOKUP, WALK, FILL, RESP, FLUSH.
- IDLE:
  - If flush_req is high, go to FLUSH. Flush has priority over requests, and i_ready and d_ready are 0 that cycle.
  - Otherwise i_ready and d_ready are driven from the grant; only the granted port sees ready = 1.
  - Grant: with one valid requester, that requester wins. With both valid, the port not granted last wins. The last-grant pointer resets to data, so fetch wins the first tie.
  - On valid && ready: latch vpn, offset, pcid and id; go to LOOKUP.
- LOOKUP:
  - lk_valid = 1 with the latched key, held until lk_done.
  - lk_done && lk_hit: go to RESP with ppn = lk_ppn; hit_cnt increments.
  - lk_done && !lk_hit: go to WALK; miss_cnt increments.
- WALK:
  - walk_valid = 1, held until walk_done.
  - walk_fault: go to RESP with fault.
  - Otherwise: latch walk_ppn and go to FILL.
- FILL: fill_en = 1 for exactly one cycle with the latched vpn, pcid and ppn; go to RESP.
- RESP: rsp_valid = 1 for one cycle with rsp_id, rsp_paddr and rsp_fault; go to IDLE.
- FLUSH: tlb_inv = 1 and flush_ack = 1 for one cycle; go to IDLE. flush_req raised during a translation is serviced in the IDLE that follows RESP.
- Counters: CNT bits, saturate at all-ones, never wrap.
- Reset:
  - Every output is 0; hit_cnt and miss_cnt are 0; state is IDLE.
  - Reset mid-translation abandons it: no response and no fill.
- Stray strobes: lk_done or walk_done arriving outside LOOKUP or WALK is ignored.
- Payload stability: request payload is sampled only at handshake, so later changes on i_vaddr or d_vaddr have no effect.

## Timing
- Handshake at edge N (IDLE). lk_valid is high from cycle N+1.
- Hit with lk_done at cycle N+1: rsp_valid at N+2. Minimum hit latency is 2 cycles from handshake to response.
- Miss with lk_done at N+1:
  - walk_valid from N+2.
  - walk_done at cycle W, no fault: fill_en at W+1, rsp_valid at W+2.
  - walk_done at W with fault: rsp_valid at W+1, no fill_en.
- The next handshake is possible in the cycle after RESP. Throughput is at most one translation per 3 cycles.
- flush_req high in IDLE at cycle F: tlb_inv and flush_ack at F+1; requests accepted again from F+2.
- All outputs are registered state decodes or latched values; there are no combinational input-to-output paths except i_ready and d_ready, which depend on i_valid, d_valid and flush_req.

## Test plan
- Reset, then fetch vaddr 0x0000_0000_0040_1ABC, pcid 5; TB returns lk_done and lk_hit with ppn 0x77 one cycle later. Required: rsp_valid 2 cycles after the handshake, rsp_id 0, rsp_paddr 0x77ABC, hit_cnt 1.
- Data vaddr 0x2000_3123; TB misses, walk_done 4 cycles later with ppn 0x99. Required: fill_en with vpn 0x20003 and ppn 0x99, then rsp_paddr 0x99123, miss_cnt 1.
- Walk returns walk_fault. Required: no fill_en; rsp_fault 1 and rsp_paddr 0.
- Both ports valid continuously for 4 translations. Required grant order fetch, data, fetch, data.
- flush_req asserted during WALK. Required: tlb_inv exactly once, in the cycle after the response's IDLE, before the next request is accepted. Reset asserted mid-WALK then released: no rsp_valid, counters 0.
- Force 2^CNT+3 hits. Required: hit_cnt holds at all-ones.

Source files
------------

// File: rtl/tlb_ctrl.sv
// Translation sequencer in front of the TLB array: round-robin port arbitration,
// lookup, page-walk refill on miss, serialized full invalidation and saturating stats.
module tlb_ctrl #(
    parameter int ADDR = 64,
    parameter int PAGE = 12,
    parameter int PCID = 12,
    parameter int CNT  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [ADDR-1:0]      i_vaddr,
    input  logic [PCID-1:0]      i_pcid,
    input  logic                 d_valid,
    output logic                 d_ready,
    input  logic [ADDR-1:0]      d_vaddr,
    input  logic [PCID-1:0]      d_pcid,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [ADDR-1:0]      rsp_paddr,
    output logic                 rsp_fault,
    output logic                 lk_valid,
    output logic [ADDR-PAGE-1:0] lk_vpn,
    output logic [PCID-1:0]      lk_pcid,
    input  logic                 lk_done,
    input  logic                 lk_hit,
    input  logic [ADDR-PAGE-1:0] lk_ppn,
    output logic                 walk_valid,
    output logic [ADDR-PAGE-1:0] walk_vpn,
    output logic [PCID-1:0]      walk_pcid,
    input  logic                 walk_done,
    input  logic                 walk_fault,
    input  logic [ADDR-PAGE-1:0] walk_ppn,
    output logic                 fill_en,
    output logic [ADDR-PAGE-1:0] fill_vpn,
    output logic [PCID-1:0]      fill_pcid,
    output logic [ADDR-PAGE-1:0] fill_ppn,
    input  logic                 flush_req,
    output logic                 tlb_inv,
    output logic                 flush_ack,
    output logic [CNT-1:0]       hit_cnt,
    output logic [CNT-1:0]       miss_cnt
);

    localparam int VPN = ADDR - PAGE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WALK   = 3'd2,
        FILL   = 3'd3,
        RESP   = 3'd4,
        FLUSH  = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [VPN-1:0]  vpn_r;
    logic [VPN-1:0]  ppn_r;
    logic [PAGE-1:0] off_r;
    logic [PCID-1:0] pcid_r;
    logic            id_r;
    logic            fault_r;
    logic            last_d_r;
    logic            gnt_i_s;
    logic            gnt_d_s;
    logic            accept_s;
    logic            hs_s;
    logic [CNT-1:0]  hit_cnt_r;
    logic [CNT-1:0]  miss_cnt_r;

    function automatic logic [CNT-1:0] sat_inc(input logic [CNT-1:0] v);
        return (&v) ? v : v + {{(CNT-1){1'b0}}, 1'b1};
    endfunction

    // Round-robin grant; last_d_r resets to data so fetch wins the first tie
    always_comb begin
        gnt_i_s = 1'b0;
        gnt_d_s = 1'b0;
        if (i_valid && d_valid) begin
            gnt_i_s = last_d_r;
            gnt_d_s = ~last_d_r;
        end else begin
            gnt_i_s = i_valid;
            gnt_d_s = d_valid;
        end
    end

    assign accept_s = (state_r == IDLE) && !flush_req;
    assign i_ready  = accept_s && gnt_i_s;
    assign d_ready  = accept_s && gnt_d_s;
    assign hs_s     = accept_s && (i_valid || d_valid);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; flush takes precedence over new requests in IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (flush_req) begin
                    state_nxt_s = FLUSH;
                end else if (hs_s) begin
                    state_nxt_s = LOOKUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOOKUP: begin
                if (lk_done) begin
                    state_nxt_s = lk_hit ? RESP : WALK;
                end else begin
                    state_nxt_s = LOOKUP;
                end
            end
            WALK: begin
                if (walk_done) begin
                    state_nxt_s = walk_fault ? RESP : FILL;
                end else begin
                    state_nxt_s = WALK;
                end
            end
            FILL:    state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            FLUSH:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request key capture at handshake and translation result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vpn_r    <= {VPN{1'b0}};
            ppn_r    <= {VPN{1'b0}};
            off_r    <= {PAGE{1'b0}};
            pcid_r   <= {PCID{1'b0}};
            id_r     <= 1'b0;
            fault_r  <= 1'b0;
            last_d_r <= 1'b1;
        end else begin
            if (hs_s) begin
                vpn_r    <= gnt_d_s ? d_vaddr[ADDR-1:PAGE] : i_vaddr[ADDR-1:PAGE];
                off_r    <= gnt_d_s ? d_vaddr[PAGE-1:0] : i_vaddr[PAGE-1:0];
                pcid_r   <= gnt_d_s ? d_pcid : i_pcid;
                id_r     <= gnt_d_s;
                last_d_r <= gnt_d_s;
                fault_r  <= 1'b0;
            end
            if ((state_r == LOOKUP) && lk_done && lk_hit) begin
                ppn_r <= lk_ppn;
            end
            if ((state_r == WALK) && walk_done) begin
                fault_r <= walk_fault;
                if (!walk_fault) begin
                    ppn_r <= walk_ppn;
                end
            end
        end
    end

    // Saturating hit/miss statistics, counted once per completed lookup
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_r  <= {CNT{1'b0}};
            miss_cnt_r <= {CNT{1'b0}};
        end else if ((state_r == LOOKUP) && lk_done) begin
            if (lk_hit) begin
                hit_cnt_r <= sat_inc(hit_cnt_r);
            end else begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end
        end
    end

    assign lk_valid   = (state_r == LOOKUP);
    assign lk_vpn     = vpn_r;
    assign lk_pcid    = pcid_r;
    assign walk_valid = (state_r == WALK);
    assign walk_vpn   = vpn_r;
    assign walk_pcid  = pcid_r;
    assign fill_en    = (state_r == FILL);
    assign fill_vpn   = vpn_r;
    assign fill_pcid  = pcid_r;
    assign fill_ppn   = ppn_r;
    assign rsp_valid  = (state_r == RESP);
    assign rsp_id     = rsp_valid & id_r;
    assign rsp_fault  = rsp_valid & fault_r;
    assign rsp_paddr  = (rsp_valid && !fault_r) ? {ppn_r, off_r} : {ADDR{1'b0}};
    assign tlb_inv    = (state_r == FLUSH);
    assign flush_ack  = (state_r == FLUSH);
    assign hit_cnt    = hit_cnt_r;
    assign miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: the bench plays the TLB array and page walker, and a
// response scoreboard holds the expected translation for every accepted request.
module tb_tlb_ctrl;

    localparam int CNT_TB = 8;
    localparam int SAT    = (1 << CNT_TB) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_ready, d_valid, d_ready;
    logic [63:0] i_vaddr, d_vaddr;
    logic [11:0] i_pcid, d_pcid;
    logic        rsp_valid, rsp_id, rsp_fault;
    logic [63:0] rsp_paddr;
    logic        lk_valid, lk_done, lk_hit;
    logic [51:0] lk_vpn, lk_ppn;
    logic [11:0] lk_pcid;
    logic        walk_valid, walk_done, walk_fault;
    logic [51:0] walk_vpn, walk_ppn;
    logic [11:0] walk_pcid;
    logic        fill_en;
    logic [51:0] fill_vpn, fill_ppn;
    logic [11:0] fill_pcid;
    logic        flush_req, tlb_inv, flush_ack;
    logic [CNT_TB-1:0] hit_cnt, miss_cnt;

    typedef struct {
        logic        id;
        logic [63:0] paddr;
        logic        fault;
    } rsp_t;

    rsp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   hits_m = 0;
    int   misses_m = 0;
    int   inv_cnt = 0;

    tlb_ctrl #(.ADDR(64), .PAGE(12), .PCID(12), .CNT(CNT_TB)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i_vaddr(i_vaddr), .i_pcid(i_pcid),
        .d_valid(d_valid), .d_ready(d_ready), .d_vaddr(d_vaddr), .d_pcid(d_pcid),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_paddr(rsp_paddr), .rsp_fault(rsp_fault),
        .lk_valid(lk_valid), .lk_vpn(lk_vpn), .lk_pcid(lk_pcid),
        .lk_done(lk_done), .lk_hit(lk_hit), .lk_ppn(lk_ppn),
        .walk_valid(walk_valid), .walk_vpn(walk_vpn), .walk_pcid(walk_pcid),
        .walk_done(walk_done), .walk_fault(walk_fault), .walk_ppn(walk_ppn),
        .fill_en(fill_en), .fill_vpn(fill_vpn), .fill_pcid(fill_pcid), .fill_ppn(fill_ppn),
        .flush_req(flush_req), .tlb_inv(tlb_inv), .flush_ack(flush_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tlb_inv) inv_cnt <= inv_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] sat(input int v);
        return (v > SAT) ? 64'(SAT) : 64'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        logic got;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (i_ready || d_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_rsp();
        rsp_t e;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_paddr", rsp_paddr, e.paddr);
            chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
        end
        chk("hit_cnt", 64'(hit_cnt), sat(hits_m));
        chk("miss_cnt", 64'(miss_cnt), sat(misses_m));
    endtask

    // One translation on the given port; the bench answers as TLB and walker
    task automatic xlate(input logic port, input logic [63:0] va, input logic [11:0] pc,
                         input logic hit, input logic [51:0] ppn, input int wdelay,
                         input logic wfault);
        rsp_t e;
        @(negedge clk);
        if (port) begin
            d_valid = 1'b1; d_vaddr = va; d_pcid = pc;
        end else begin
            i_valid = 1'b1; i_vaddr = va; i_pcid = pc;
        end
        wait_ready();
        chk("grant_port", 64'(d_ready), 64'(port));
        e.id    = port;
        e.fault = wfault && !hit;
        e.paddr = e.fault ? 64'd0 : {ppn, va[11:0]};
        sb.push_back(e);
        @(negedge clk);
        i_valid = 1'b0; d_valid = 1'b0;
        i_vaddr = '1; d_vaddr = '1; i_pcid = '1; d_pcid = '1;
        chk("lk_valid", 64'(lk_valid), 64'd1);
        chk("lk_vpn", 64'(lk_vpn), va >> 12);
        chk("lk_pcid", 64'(lk_pcid), 64'(pc));
        chk("rsp_early", 64'(rsp_valid), 64'd0);
        lk_done = 1'b1; lk_hit = hit; lk_ppn = hit ? ppn : ~ppn;
        @(negedge clk);
        lk_done = 1'b0; lk_hit = 1'b0;
        if (hit) hits_m++; else misses_m++;
        if (!hit) begin
            chk("walk_valid", 64'(walk_valid), 64'd1);
            chk("walk_vpn", 64'(walk_vpn), va >> 12);
            chk("walk_pcid", 64'(walk_pcid), 64'(pc));
            for (int k = 1; k < wdelay; k++) begin
                @(negedge clk);
                chk("walk_hold", 64'(walk_valid), 64'd1);
            end
            walk_done = 1'b1; walk_fault = wfault; walk_ppn = ppn;
            @(negedge clk);
            walk_done = 1'b0; walk_fault = 1'b0; walk_ppn = '0;
            if (!wfault) begin
                chk("fill_en", 64'(fill_en), 64'd1);
                chk("fill_vpn", 64'(fill_vpn), va >> 12);
                chk("fill_pcid", 64'(fill_pcid), 64'(pc));
                chk("fill_ppn", 64'(fill_ppn), 64'(ppn));
                chk("rsp_before_fill", 64'(rsp_valid), 64'd0);
                @(negedge clk);
                chk("fill_once", 64'(fill_en), 64'd0);
            end else begin
                chk("no_fill_on_fault", 64'(fill_en), 64'd0);
            end
        end
        check_rsp();
    endtask

    initial begin
        rsp_t e;
        int   inv0;
        logic got;
        rst_n = 1'b0;
        i_valid = 1'b0; d_valid = 1'b0; i_vaddr = '0; d_vaddr = '0; i_pcid = '0; d_pcid = '0;
        lk_done = 1'b0; lk_hit = 1'b0; lk_ppn = '0;
        walk_done = 1'b0; walk_fault = 1'b0; walk_ppn = '0; flush_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 64'({rsp_valid, rsp_id, rsp_fault, lk_valid, walk_valid, fill_en,
                                tlb_inv, flush_ack, i_ready, d_ready}), 64'd0);
        chk("rst_paddr", rsp_paddr, 64'd0);
        chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        rst_n = 1'b1;

        xlate(1'b0, 64'h0000_0000_0040_1ABC, 12'd5, 1'b1, 52'h77, 0, 1'b0);
        xlate(1'b1, 64'h0000_0000_2000_3123, 12'd9, 1'b0, 52'h99, 4, 1'b0);
        xlate(1'b1, 64'h0000_0000_3000_5456, 12'd3, 1'b0, 52'h55, 2, 1'b1);

        // Round robin with both ports continuously valid
        @(negedge clk);
        i_valid = 1'b1; i_vaddr = 64'h1000_0111; i_pcid = 12'd1;
        d_valid = 1'b1; d_vaddr = 64'h2000_0222; d_pcid = 12'd2;
        for (int k = 0; k < 4; k++) begin
            wait_ready();
            chk("rr_grant", 64'(d_ready), 64'(k[0]));
            chk("rr_onehot", 64'(i_ready & d_ready), 64'd0);
            e.id = k[0];
            e.fault = 1'b0;
            e.paddr = {52'h10 + 52'(k), k[0] ? 12'h222 : 12'h111};
            sb.push_back(e);
            @(negedge clk);
            lk_done = 1'b1; lk_hit = 1'b1; lk_ppn = 52'h10 + 52'(k);
            @(negedge clk);
            lk_done = 1'b0; lk_hit = 1'b0;
            hits_m++;
            check_rsp();
            if (k == 3) begin
                i_valid = 1'b0; d_valid = 1'b0;
            end
        end

        // Flush raised mid-walk is serviced after the response, ahead of a pending fetch
        @(negedge clk);
        d_valid = 1'b1; d_vaddr = 64'h4000_5678; d_pcid = 12'd4;
        wait_ready();
        e.id = 1'b1; e.fault = 1'b0; e.paddr = 64'hAB678;
        sb.push_back(e);
        @(negedge clk);
        d_valid = 1'b0;
        i_valid = 1'b1; i_vaddr = 64'h5000_0001; i_pcid = 12'd6;
        lk_done = 1'b1; lk_hit = 1'b0;
        @(negedge clk);
        lk_done = 1'b0;
        misses_m++;
        inv0 = inv_cnt;
        flush_req = 1'b1;
        @(negedge clk);
        chk("flush_in_walk", 64'(tlb_inv), 64'd0);
        walk_done = 1'b1; walk_ppn = 52'hAB;
        @(negedge clk);
        walk_done = 1'b0;
        chk("flush_fill", 64'(fill_en), 64'd1);
        @(negedge clk);
        check_rsp();
        @(negedge clk);
        #1;
        chk("flush_prio_ready", 64'(i_ready), 64'd0);
        chk("flush_not_yet", 64'(tlb_inv), 64'd0);
        @(negedge clk);
        chk("flush_inv", 64'(tlb_inv), 64'd1);
        chk("flush_ack", 64'(flush_ack), 64'd1);
        chk("flush_no_lookup", 64'(lk_valid), 64'd0);
        flush_req = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_done", 64'(tlb_inv), 64'd0);
        chk("post_flush_ready", 64'(i_ready), 64'd1);
        e.id = 1'b0; e.fault = 1'b0; e.paddr = 64'hCD001;
        sb.push_back(e);
        @(negedge clk);
        i_valid = 1'b0;
        lk_done = 1'b1; lk_hit = 1'b1; lk_ppn = 52'hCD;
        @(negedge clk);
        lk_done = 1'b0; lk_hit = 1'b0;
        hits_m++;
        check_rsp();
        repeat (2) @(negedge clk);
        chk("inv_once", 64'(inv_cnt - inv0), 64'd1);

        // Reset mid-walk abandons the translation; stray strobes afterwards are ignored
        i_valid = 1'b1; i_vaddr = 64'h6000_0000; i_pcid = 12'd7;
        wait_ready();
        @(negedge clk);
        i_valid = 1'b0;
        lk_done = 1'b1; lk_hit = 1'b0;
        @(negedge clk);
        lk_done = 1'b0;
        chk("pre_rst_walk", 64'(walk_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_walk_drop", 64'(walk_valid), 64'd0);
        chk("rst_hit_clr", 64'(hit_cnt), 64'd0);
        chk("rst_miss_clr", 64'(miss_cnt), 64'd0);
        rst_n = 1'b1;
        hits_m = 0; misses_m = 0;
        walk_done = 1'b1; walk_ppn = 52'h1;
        @(negedge clk);
        walk_done = 1'b0;
        lk_done = 1'b1; lk_hit = 1'b1;
        @(negedge clk);
        lk_done = 1'b0; lk_hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_quiet", 64'({rsp_valid, fill_en, walk_valid, lk_valid}), 64'd0);
            @(negedge clk);
        end
        chk("stray_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("stray_miss_cnt", 64'(miss_cnt), 64'd0);

        // Saturation: lookup answers held high so every request hits immediately
        i_valid = 1'b1; i_vaddr = 64'h7000_0ABC; i_pcid = 12'd8;
        lk_done = 1'b1; lk_hit = 1'b1; lk_ppn = 52'h5;
        for (int k = 0; k < SAT + 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) chk("sat_rsp_timeout", 64'd0, 64'd1);
            hits_m++;
            chk("hit_sat", 64'(hit_cnt), sat(hits_m));
        end
        i_valid = 1'b0; lk_done = 1'b0; lk_hit = 1'b0;
        repeat (3) @(negedge clk);
        chk("hit_hold_ones", 64'(hit_cnt), 64'(SAT));
        chk("miss_after_sat", 64'(miss_cnt), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
